// File: rtl/cmd_stream_assembler.sv
// cmd_stream_assembler: packs UART bytes into command words and queues them
// in a first-word-fall-through FIFO toward an AXI-Stream consumer.
module cmd_stream_assembler #(
  parameter int BYTES_PER_WORD = 4,
  parameter int MSB_FIRST      = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                            clk,
  input  logic                            reset_n_i,
  input  logic                            clear_i,
  input  logic                            rx_valid_i,
  input  logic                            rx_busy_i,
  input  logic [7:0]                      rx_data_i,
  output logic                            rx_rd_o,
  output logic                            cmd_axis_tvalid_o,
  input  logic                            cmd_axis_tready_i,
  output logic [8*BYTES_PER_WORD-1:0]     cmd_axis_tdata_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            partial_o,
  output logic                            timeout_o
);

  localparam int W       = 8 * BYTES_PER_WORD;
  localparam int CW      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  // A single-byte word never holds a partial, so the timeout can never apply.
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0) && (BYTES_PER_WORD > 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BYTES_PER_WORD - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TO_LAST);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  word_q, word_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  mem_q [FIFO_DEPTH];

  logic          accept, cnt_last, push, pop;
  logic [CW-1:0] lane;
  logic [W-1:0]  push_word;

  // Handshake decode; rx_rd_o depends on registered state only, so a pop in
  // the same cycle cannot open the gate for the word-completing byte.
  assign cnt_last = (cnt_q == CNT_LAST);
  assign rx_rd_o  = !cnt_last || (level_q != LVL_FULL);
  assign accept   = rx_valid_i && !rx_busy_i && rx_rd_o;
  assign push     = accept && cnt_last;
  assign pop      = (level_q != '0) && cmd_axis_tready_i;

  // Merge the incoming byte into the lane chosen by byte count and order.
  always_comb begin
    lane      = (MSB_FIRST != 0) ? (CNT_LAST - cnt_q) : cnt_q;
    push_word = word_q;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      if (lane == CW'(i)) push_word[8*i +: 8] = rx_data_i;
  end

  // Byte counter, partial word and idle-timeout next state.
  always_comb begin
    cnt_d     = cnt_q;
    word_d    = word_q;
    idle_d    = idle_q;
    timeout_d = 1'b0;
    if (accept) begin
      idle_d = '0;
      if (cnt_last) begin
        cnt_d  = '0;
        word_d = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        word_d = push_word;
      end
    end else if (cnt_q == '0) begin
      idle_d = '0;
    end else if (TO_EN) begin
      if (idle_q == IDLE_LAST) begin
        cnt_d     = '0;
        word_d    = '0;
        idle_d    = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
    if (clear_i) begin
      cnt_d     = '0;
      word_d    = '0;
      idle_d    = '0;
      timeout_d = 1'b0;
    end
  end

  // FIFO pointer and occupancy next state; clear wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Assembler and FIFO control registers.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q     <= '0;
      word_q    <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // FIFO storage; completed word is written in the cycle of its last byte.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !clear_i) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign cmd_axis_tvalid_o = (level_q != '0);
  assign cmd_axis_tdata_o  = cmd_axis_tvalid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_level_o      = level_q;
  assign partial_o         = (cnt_q != '0);
  assign timeout_o         = timeout_q;

endmodule
